// File: rtl/cc_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cc_tag_ctrl
// Purpose  : Tag-array write-port sequencer for the 8-way icache. It handles
//            the init sweep, arbitrates fills and invalidates, and reports
//            eviction and status.
// Revision : 1.0
// ============================================================================
module cc_tag_ctrl #(
    parameter int SET_BITS = 7,
    parameter int WAYS     = 8,
    parameter int PADDR_W  = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_req,
    input  logic                       fill_req,
    input  logic [PADDR_W-1:0]         fill_addr,
    output logic                       fill_ack,
    input  logic                       inv_req,
    input  logic [PADDR_W-1:0]         inv_addr,
    output logic                       inv_ack,
    output logic [PADDR_W-1:0]         tag_write_addr,
    output logic                       tag_write_wen,
    output logic                       tag_invalidate,
    output logic                       tag_init,
    input  logic [WAYS-1:0]            way_write_hit,
    input  logic [WAYS-1:0]            way_exp_en,
    input  logic [WAYS*PADDR_W-1:0]    way_expun_addr,
    output logic                       evict_valid,
    output logic [PADDR_W-1:0]         evict_addr,
    output logic                       inv_done,
    output logic                       inv_hit,
    output logic                       err_no_victim,
    output logic                       err_multi,
    output logic                       init_busy
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_IDLE  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    localparam logic [SET_BITS:0] c_CNT_ONE = {{SET_BITS{1'b0}}, 1'b1};
    localparam logic [WAYS-1:0]   c_WAY_ONE = {{(WAYS-1){1'b0}}, 1'b1};

    state_t               r_state, w_state_nxt;
    logic [SET_BITS:0]    r_set_cnt, w_set_cnt_nxt, w_set_cnt_inc;
    logic                 r_drain, w_drain_nxt;
    logic                 r_init_pend, w_init_pend_nxt;
    logic                 r_op_inv, w_op_inv_nxt;
    logic [PADDR_W-1:0]   r_op_addr, w_op_addr_nxt;

    logic                 w_fill_ack, w_inv_ack;
    logic [PADDR_W-1:0]   w_tag_addr;
    logic                 w_wen, w_inval, w_init, w_busy;

    logic [PADDR_W-1:0]   w_way_addr [WAYS];
    logic                 w_any_hit, w_multi_hit, w_sel_exp;
    logic [PADDR_W-1:0]   w_sel_addr;

    logic                 r_evict_valid, r_inv_done, r_inv_hit;
    logic                 r_err_no_victim, r_err_multi;
    logic [PADDR_W-1:0]   r_evict_addr;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign w_way_addr[gi] = way_expun_addr[gi*PADDR_W +: PADDR_W];
        end
    endgenerate

    assign w_set_cnt_inc = r_set_cnt + c_CNT_ONE;
    assign w_any_hit     = |way_write_hit;
    // Clearing the lowest set bit leaves something only if two or more ways hit.
    assign w_multi_hit   = |(way_write_hit & (way_write_hit - c_WAY_ONE));

    // OR-select is exact whenever a single way hits; other cases are errors.
    always_comb begin
        w_sel_exp  = 1'b0;
        w_sel_addr = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_write_hit[w]) begin
                w_sel_exp  = w_sel_exp | way_exp_en[w];
                w_sel_addr = w_sel_addr | w_way_addr[w];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_set_cnt_nxt   = r_set_cnt;
        w_drain_nxt     = r_drain;
        w_init_pend_nxt = r_init_pend;
        w_op_inv_nxt    = r_op_inv;
        w_op_addr_nxt   = r_op_addr;
        w_fill_ack      = 1'b0;
        w_inv_ack       = 1'b0;
        w_tag_addr      = '0;
        w_wen           = 1'b0;
        w_inval         = 1'b0;
        w_init          = 1'b0;
        w_busy          = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init        = 1'b1;
                w_busy        = 1'b1;
                w_tag_addr    = PADDR_W'(r_set_cnt[SET_BITS-1:0]);
                w_set_cnt_nxt = w_set_cnt_inc;
                if (w_set_cnt_inc[SET_BITS]) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = 1'b0;
                end
            end
            ST_DRAIN: begin
                w_busy      = 1'b1;
                w_drain_nxt = 1'b1;
                if (r_drain) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init_req || r_init_pend) begin
                    w_state_nxt     = ST_INIT;
                    w_set_cnt_nxt   = '0;
                    w_init_pend_nxt = 1'b0;
                end else if (inv_req) begin
                    w_inv_ack     = 1'b1;
                    w_op_inv_nxt  = 1'b1;
                    w_op_addr_nxt = inv_addr;
                    w_state_nxt   = ST_ISSUE;
                end else if (fill_req) begin
                    w_fill_ack    = 1'b1;
                    w_op_inv_nxt  = 1'b0;
                    w_op_addr_nxt = fill_addr;
                    w_state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_tag_addr  = r_op_addr;
                w_wen       = ~r_op_inv;
                w_inval     = r_op_inv;
                w_state_nxt = ST_CHECK;
                if (init_req) begin
                    w_init_pend_nxt = 1'b1;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
                if (init_req) begin
                    w_init_pend_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_INIT;
                w_set_cnt_nxt = '0;
            end
        endcase
    end

    // The tag arrays update on the falling edge, so this block does too.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_set_cnt   <= '0;
            r_drain     <= 1'b0;
            r_init_pend <= 1'b0;
            r_op_inv    <= 1'b0;
            r_op_addr   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_set_cnt   <= w_set_cnt_nxt;
            r_drain     <= w_drain_nxt;
            r_init_pend <= w_init_pend_nxt;
            r_op_inv    <= w_op_inv_nxt;
            r_op_addr   <= w_op_addr_nxt;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_evict_valid   <= 1'b0;
            r_evict_addr    <= '0;
            r_inv_done      <= 1'b0;
            r_inv_hit       <= 1'b0;
            r_err_no_victim <= 1'b0;
            r_err_multi     <= 1'b0;
        end else begin
            r_evict_valid   <= 1'b0;
            r_evict_addr    <= '0;
            r_inv_done      <= 1'b0;
            r_inv_hit       <= 1'b0;
            r_err_no_victim <= 1'b0;
            r_err_multi     <= 1'b0;
            if (r_state == ST_CHECK) begin
                if (r_op_inv) begin
                    r_inv_done  <= 1'b1;
                    r_inv_hit   <= w_any_hit;
                    r_err_multi <= w_multi_hit;
                end else if (!w_any_hit) begin
                    r_err_no_victim <= 1'b1;
                end else if (w_multi_hit) begin
                    r_err_multi <= 1'b1;
                end else begin
                    r_evict_valid <= w_sel_exp;
                    r_evict_addr  <= w_sel_exp ? w_sel_addr : '0;
                end
            end
        end
    end

    assign fill_ack       = w_fill_ack;
    assign inv_ack        = w_inv_ack;
    assign tag_write_addr = w_tag_addr;
    assign tag_write_wen  = w_wen;
    assign tag_invalidate = w_inval;
    assign tag_init       = w_init;
    assign init_busy      = w_busy;
    assign evict_valid    = r_evict_valid;
    assign evict_addr     = r_evict_addr;
    assign inv_done       = r_inv_done;
    assign inv_hit        = r_inv_hit;
    assign err_no_victim  = r_err_no_victim;
    assign err_multi      = r_err_multi;

endmodule
`default_nettype wire
